// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin codes, controller state encodings
// and the monetary value of one credit unit.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_C1   = 2'b01,
        COIN_C2   = 2'b10,
        COIN_C3   = 2'b11
    } coin_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_REFUND  = 2'b10,
        ST_ILLEGAL = 2'b11
    } vend_state_e;

    // One credit unit is R$0,25.
    localparam int UNIT_CENTS = 25;

endpackage

// File: rtl/inactivity_timer.sv
// Idle-cycle counter: clears on load, counts while enabled, and flags expiry
// on the cycle the count reaches TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES is 0).
module inactivity_timer #(
    parameter int TMR_W          = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam logic [TMR_W-1:0] LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: adds coins up to a ceiling, deducts purchases,
// returns change on refund request or inactivity timeout.
module coin_credit_accumulator
    import vending_pkg::*;
#(
    parameter int CREDIT_W       = 4,
    parameter int MAX_CREDIT     = 8,
    parameter int COIN1_UNITS    = 1,
    parameter int COIN2_UNITS    = 2,
    parameter int COIN3_UNITS    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                buy_req,
    input  logic [CREDIT_W-1:0] price,
    input  logic                refund_req,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic                buy_ack,
    output logic                buy_nack,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic [1:0]          state
);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
    logic                coin_accept_q, coin_accept_d;
    logic                coin_reject_q, coin_reject_d;
    logic                buy_ack_q, buy_ack_d;
    logic                buy_nack_q, buy_nack_d;
    logic                change_valid_q, change_valid_d;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                price_ok;
    logic                refund_evt;
    logic                tmr_load;
    logic                tmr_clear;
    logic                tmr_enable;
    logic                tmr_expire;

    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W:0] v;
        v = '0;
        case (code)
            COIN_C1: v = (CREDIT_W+1)'(COIN1_UNITS);
            COIN_C2: v = (CREDIT_W+1)'(COIN2_UNITS);
            COIN_C3: v = (CREDIT_W+1)'(COIN3_UNITS);
            default: v = '0;
        endcase
        return v;
    endfunction

    // One extra bit so an overflowing coin is detected instead of wrapping.
    assign coin_sum   = {1'b0, credit_q} + coin_value(coin_code);
    assign coin_ok    = (coin_code != COIN_NONE) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign price_ok   = (price != '0) && (price <= credit_q);
    assign refund_evt = refund_req || tmr_expire;

    // NOTE: every always_comb output gets a default first, so no latches are inferred.
    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        change_amount_d = change_amount_q;
        coin_accept_d   = 1'b0;
        coin_reject_d   = 1'b0;
        buy_ack_d       = 1'b0;
        buy_nack_d      = 1'b0;
        change_valid_d  = 1'b0;
        tmr_load        = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (refund_evt && (state_q == ST_COLLECT)) begin
                    change_amount_d = credit_q;
                    change_valid_d  = 1'b1;
                    credit_d        = '0;
                    state_d         = ST_REFUND;
                    coin_reject_d   = coin_valid;
                    buy_nack_d      = buy_req;
                end else if (buy_req) begin
                    coin_reject_d = coin_valid;
                    if (price_ok) begin
                        credit_d  = credit_q - price;
                        buy_ack_d = 1'b1;
                        tmr_load  = 1'b1;
                        state_d   = (credit_q == price) ? ST_IDLE : ST_COLLECT;
                    end else begin
                        buy_nack_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d      = coin_sum[CREDIT_W-1:0];
                        coin_accept_d = 1'b1;
                        tmr_load      = 1'b1;
                        state_d       = ST_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_REFUND: begin
                state_d       = ST_IDLE;
                coin_reject_d = coin_valid;
                buy_nack_d    = buy_req;
            end
            default: begin
                state_d       = ST_IDLE;
                credit_d      = '0;
                coin_reject_d = coin_valid;
                buy_nack_d    = buy_req;
            end
        endcase
    end

    // Timer only runs while collecting; it is held at zero everywhere else.
    assign tmr_enable = (state_q == ST_COLLECT);
    assign tmr_clear  = tmr_load || (state_d != ST_COLLECT);

    inactivity_timer #(
        .TMR_W          (TMR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_clear),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            credit_q        <= '0;
            change_amount_q <= '0;
            coin_accept_q   <= 1'b0;
            coin_reject_q   <= 1'b0;
            buy_ack_q       <= 1'b0;
            buy_nack_q      <= 1'b0;
            change_valid_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            change_amount_q <= change_amount_d;
            coin_accept_q   <= coin_accept_d;
            coin_reject_q   <= coin_reject_d;
            buy_ack_q       <= buy_ack_d;
            buy_nack_q      <= buy_nack_d;
            change_valid_q  <= change_valid_d;
        end
    end

    assign credit        = credit_q;
    assign change_amount = change_amount_q;
    assign coin_accept   = coin_accept_q;
    assign coin_reject   = coin_reject_q;
    assign buy_ack       = buy_ack_q;
    assign buy_nack      = buy_nack_q;
    assign change_valid  = change_valid_q;
    assign state         = state_q;

endmodule
